// File: rtl/pht_nbit_gshare.sv
// Pattern history table of CTR_BITS saturating counters with an optional gshare
// index hash (define PHT_GSHARE_EN). After reset the table is swept to weakly-not-taken.
module pht_nbit_gshare #(
  parameter int INDEX_LEN = 10,
  parameter int CTR_BITS  = 2,
  parameter int HIST_LEN  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INDEX_LEN-1:0] index_read,
  input  logic [INDEX_LEN-1:0] index_write,
  input  logic                 write_enabled,
  input  logic                 increment_decrement,
  output logic [CTR_BITS-1:0]  count,
  output logic                 predict_taken,
  output logic                 ready,
  output logic [HIST_LEN-1:0]  history
);

  localparam int LOCATIONS = 2**INDEX_LEN;
  localparam logic [CTR_BITS-1:0] WNT  = CTR_BITS'((2**(CTR_BITS-1)) - 1);
  localparam logic [CTR_BITS-1:0] CMAX = '1;

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic                 en;
    logic [INDEX_LEN-1:0] addr;
    logic [CTR_BITS-1:0]  data;
  } tbl_wr_t;

  state_t               state_q, state_d;
  logic [INDEX_LEN-1:0] sweep_q, sweep_d;
  logic [CTR_BITS-1:0]  count_q, count_d;
  logic [CTR_BITS-1:0]  table_q [LOCATIONS];

  logic [INDEX_LEN-1:0] hist_ext;
  logic [INDEX_LEN-1:0] eff_rd, eff_wr;
  logic                 upd_acc;
  logic [CTR_BITS-1:0]  upd_old, upd_new;
  tbl_wr_t              tbl_wr;

  // Updates only count once the table is fully initialised.
  assign upd_acc = (state_q == RUN) && write_enabled;

`ifdef PHT_GSHARE_EN
  logic [HIST_LEN-1:0] history_q, history_d;

  always_comb begin
    history_d = history_q;
    if (upd_acc) begin
      history_d    = history_q << 1;
      history_d[0] = increment_decrement;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) history_q <= '0;
    else       history_q <= history_d;
  end

  // Both ports hash with the pre-shift history of this cycle.
  always_comb begin
    hist_ext                = '0;
    hist_ext[HIST_LEN-1:0]  = history_q;
  end

  assign history = history_q;
`else
  assign hist_ext = '0;
  assign history  = '0;
`endif

  assign eff_rd = index_read  ^ hist_ext;
  assign eff_wr = index_write ^ hist_ext;

  // Saturating counter step.
  always_comb begin
    upd_old = table_q[eff_wr];
    upd_new = upd_old;
    if (increment_decrement) begin
      if (upd_old != CMAX) upd_new = upd_old + 1'b1;
    end else begin
      if (upd_old != '0)   upd_new = upd_old - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    tbl_wr  = '0;
    count_d = WNT;
    case (state_q)
      INIT: begin
        tbl_wr.en   = 1'b1;
        tbl_wr.addr = sweep_q;
        tbl_wr.data = WNT;
        sweep_d     = sweep_q + 1'b1;
        if (sweep_q == '1) state_d = RUN;
      end
      RUN: begin
        tbl_wr.en   = upd_acc;
        tbl_wr.addr = eff_wr;
        tbl_wr.data = upd_new;
        // Write-through so a same-cycle read sees the updated counter.
        if (upd_acc && (eff_wr == eff_rd)) count_d = upd_new;
        else                               count_d = table_q[eff_rd];
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      sweep_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && tbl_wr.en) table_q[tbl_wr.addr] <= tbl_wr.data;
  end

  assign count         = count_q;
  assign predict_taken = count_q[CTR_BITS-1];
  assign ready         = (state_q == RUN);

endmodule

// File: tb/tb_pht_nbit_gshare.sv
// Directed bench for pht_nbit_gshare at INDEX_LEN=4, CTR_BITS=2, HIST_LEN=4.
module tb_pht_nbit_gshare;
  localparam int IL = 4, CB = 2, HL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [IL-1:0] index_read, index_write;
  logic          write_enabled, increment_decrement;
  logic [CB-1:0] count;
  logic          predict_taken, ready;
  logic [HL-1:0] history;

  int total = 0;
  int bad   = 0;

  pht_nbit_gshare #(.INDEX_LEN(IL), .CTR_BITS(CB), .HIST_LEN(HL)) dut (
    .clk(clk), .reset(reset), .index_read(index_read), .index_write(index_write),
    .write_enabled(write_enabled), .increment_decrement(increment_decrement),
    .count(count), .predict_taken(predict_taken), .ready(ready), .history(history)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IL-1:0] rd;
    logic [IL-1:0] wr;
    logic          we;
    logic          inc;
    logic [CB-1:0] exp_cnt;
    logic          exp_pt;
    logic [HL-1:0] exp_hist;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int rd, wr, we, inc, cnt, pt, hist);
    vec_t v;
    v.rd = IL'(rd); v.wr = IL'(wr); v.we = we[0]; v.inc = inc[0];
    v.exp_cnt = CB'(cnt); v.exp_pt = pt[0]; v.exp_hist = HL'(hist);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
`ifdef PHT_GSHARE_EN
    vecs.push_back(mk(2, 0, 0, 0, 1, 0, 0));  // INIT write was ignored
    vecs.push_back(mk(9, 0, 1, 1, 1, 0, 1));  // entry 0 -> 2
    vecs.push_back(mk(9, 0, 1, 1, 1, 0, 3));  // eff 1: entry 1 -> 2
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 3));  // eff 3
    vecs.push_back(mk(3, 0, 0, 0, 2, 1, 3));  // eff 0
    vecs.push_back(mk(2, 0, 0, 0, 2, 1, 3));  // eff 1
`else
    vecs.push_back(mk(9, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(5, 5, 1, 1, 2, 1, 0));
    vecs.push_back(mk(5, 5, 1, 1, 3, 1, 0));
    vecs.push_back(mk(5, 5, 1, 1, 3, 1, 0));  // saturate high
    vecs.push_back(mk(5, 5, 1, 0, 2, 1, 0));
    vecs.push_back(mk(5, 5, 1, 0, 1, 0, 0));
    vecs.push_back(mk(5, 5, 1, 0, 0, 0, 0));
    vecs.push_back(mk(5, 5, 1, 0, 0, 0, 0));  // saturate low
    vecs.push_back(mk(3, 3, 1, 1, 2, 1, 0));  // bypass
    vecs.push_back(mk(3, 0, 0, 0, 2, 1, 0));
    vecs.push_back(mk(9, 6, 1, 1, 1, 0, 0));  // other index unaffected
    vecs.push_back(mk(6, 0, 0, 0, 2, 1, 0));
    vecs.push_back(mk(9, 9, 0, 1, 1, 0, 0));  // strobe low: no change
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0));
`endif

    reset = 1'b1; index_read = '0; index_write = '0;
    write_enabled = 1'b0; increment_decrement = 1'b0;
    step();
    chk("rst_ready", 32'(ready), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_pt", 32'(predict_taken), 0);
    chk("rst_hist", 32'(history), 0);

    // Sweep, with an update strobe held on index 2 that must be ignored.
    reset = 1'b0; index_read = 4'd7;
    write_enabled = 1'b1; index_write = 4'd2; increment_decrement = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("sweep_ready[%0d]", i), 32'(ready), (i == 16) ? 1 : 0);
      if (i == 1 || i == 8) chk($sformatf("init_count[%0d]", i), 32'(count), 1);
    end
    write_enabled = 1'b0;
    chk("init_hist", 32'(history), 0);

    foreach (vecs[k]) begin
      index_read = vecs[k].rd; index_write = vecs[k].wr;
      write_enabled = vecs[k].we; increment_decrement = vecs[k].inc;
      step();
      chk($sformatf("vec%0d_count", k), 32'(count), 32'(vecs[k].exp_cnt));
      chk($sformatf("vec%0d_pt", k), 32'(predict_taken), 32'(vecs[k].exp_pt));
      chk($sformatf("vec%0d_hist", k), 32'(history), 32'(vecs[k].exp_hist));
    end
    write_enabled = 1'b0;

    // Restart in RUN, then reset again on sweep cycle 8.
    reset = 1'b1; step();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("mid_ready_pre", 32'(ready), 0);
    reset = 1'b1; step();
    reset = 1'b0;
    chk("mid_ready0", 32'(ready), 0);
    chk("mid_hist", 32'(history), 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("mid_ready[%0d]", i), 32'(ready), (i == 16) ? 1 : 0);
    end
    for (int i = 0; i < 16; i++) begin
      index_read = IL'(i);
      step();
      chk($sformatf("resweep_entry[%0d]", i), 32'(count), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
